scan_sequencer: RTL



---
 rtl/scan_sequencer_pkg.sv | 21 ++
 rtl/scan_sequencer_next_slot_finder.sv | 41 ++++
 rtl/scan_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared types and sizes for the display scan sequencer.
//               Holds the sequencer state encoding, the slot count and
//               the select-bus width.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SEL_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        MANUAL = 2'd2
    } state_e;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/scan_sequencer_next_slot_finder.sv
`default_nettype none
// ============================================================================
// Module      : next_slot_finder
// Description : Combinational search for the next enabled slot after ptr_i.
//               Candidates are examined in the order ptr+1 .. ptr+7 and
//               then ptr itself (all modulo 8). The first set mask bit wins.
//               When no mask bit is set, ptr_next_o equals ptr_i.
// Ports       : ptr_i      - currently selected slot
//               mask_i     - slot enable mask
//               ptr_next_o - next enabled slot
//               found_o    - 1 when any slot is enabled
// Revision    : 1.0 - initial release
// ============================================================================
module next_slot_finder
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]     ptr_i,
    input  logic [NUM_SLOTS-1:0] mask_i,
    output logic [SEL_W-1:0]     ptr_next_o,
    output logic                 found_o
);

    logic [SEL_W-1:0] w_idx;

    // Walk the candidates from farthest to nearest so that the nearest
    // enabled slot is the one assigned last and therefore wins.
    // Offset 8 truncates to 0, which places ptr itself at lowest priority.
    always_comb begin
        ptr_next_o = ptr_i;
        found_o    = |mask_i;
        w_idx      = ptr_i;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            w_idx = ptr_i + SEL_W'(i + 1);
            if (mask_i[w_idx]) begin
                ptr_next_o = w_idx;
            end
        end
    end

endmodule : next_slot_finder
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scan_sequencer
// Description : Time-multiplexing sequencer for a 3-to-8 active-low select
//               decoder. It keeps an 8-entry digit register file and steps
//               through enabled slots, either at a prescaled rate (RUN) or
//               one slot per rising edge of step (MANUAL). Select lines,
//               slot data and the blank flag are all registered and change
//               on the same clock edge.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               en, mode, step       - scan control
//               mask                 - per-slot scan enable
//               wr_en/wr_addr/wr_data- digit register file write port
//               A2, A1, A0           - decoder select lines
//               digit_data, blank    - data and blanking for segment driver
//               wrap                 - one-cycle pulse on scan wrap-around
// Revision    : 1.0 - initial release
// ============================================================================
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int DATA_W   = 4
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 step,
    input  logic [NUM_SLOTS-1:0] mask,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 A2,
    output logic                 A1,
    output logic                 A0,
    output logic [DATA_W-1:0]    digit_data,
    output logic                 blank,
    output logic                 wrap
);

    localparam int               CNT_W    = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   presc_q,  presc_d;
    logic               step_q;
    logic [SEL_W-1:0]   ptr_q,    ptr_d;
    logic [DATA_W-1:0]  digit_q,  digit_d;
    logic               blank_q,  blank_d;
    logic               wrap_q,   wrap_d;
    logic [DATA_W-1:0]  regs_q [NUM_SLOTS];
    logic [DATA_W-1:0]  regs_d [NUM_SLOTS];

    logic               w_advance;
    logic               w_found;
    logic [SEL_W-1:0]   w_ptr_next;

    // ------------------------------------------------------------------
    // Next-slot search relative to the current pointer
    // ------------------------------------------------------------------
    next_slot_finder u_finder (
        .ptr_i      (ptr_q),
        .mask_i     (mask),
        .ptr_next_o (w_ptr_next),
        .found_o    (w_found)
    );

    // ------------------------------------------------------------------
    // State selection is a pure function of en/mode, so every state is
    // reachable from every other in a single edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = IDLE;
        if (en) begin
            state_d = mode ? MANUAL : RUN;
        end
    end

    // ------------------------------------------------------------------
    // Advance event and dwell prescaler. A state change restarts the
    // dwell and suppresses any advance on that edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_advance = 1'b0;
        presc_d   = '0;
        if (state_d == state_q) begin
            case (state_q)
                RUN: begin
                    if (presc_q == CNT_LAST) begin
                        w_advance = 1'b1;
                    end else begin
                        presc_d = presc_q + CNT_W'(1);
                    end
                end
                MANUAL: begin
                    w_advance = step & ~step_q;
                end
                default: begin
                    w_advance = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file write, forwarded into the data output so a write to
    // the slot being selected on this edge is visible immediately.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointer, data, blank and wrap next-state
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d  = ptr_q;
        wrap_d = 1'b0;
        if (w_advance && w_found) begin
            ptr_d  = w_ptr_next;
            // Moving to an index not above the current one means the
            // scan went through slot 7 back toward slot 0.
            wrap_d = (w_ptr_next <= ptr_q);
        end
        digit_d = regs_d[ptr_d];
        blank_d = (state_d == IDLE) | ~mask[ptr_d];
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            step_q  <= 1'b0;
            ptr_q   <= '0;
            digit_q <= '0;
            blank_q <= 1'b1;
            wrap_q  <= 1'b0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            step_q  <= step;
            ptr_q   <= ptr_d;
            digit_q <= digit_d;
            blank_q <= blank_d;
            wrap_q  <= wrap_d;
            regs_q  <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign A2         = ptr_q[2];
    assign A1         = ptr_q[1];
    assign A0         = ptr_q[0];
    assign digit_data = digit_q;
    assign blank      = blank_q;
    assign wrap       = wrap_q;

endmodule : scan_sequencer
`default_nettype wire
